// File: rtl/pipelined_shifter_if.sv
// Operand/result bus of the pipelined shifter: input op handshake plus result handshake.
interface pipelined_shifter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_err;

    // Producer of ops / consumer of results
    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

    // The shifter itself
    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL/ROL) with valid/ready handshake and sideband tag.
// Each register stage resolves LVL_PER_REG shift levels; the whole pipe advances or holds as one.
module pipelined_shifter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LVL_PER_REG = 1,
    parameter int unsigned TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    output logic                  busy,
    pipelined_shifter_if.slave    bus
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned LAT = (SHW + LVL_PER_REG - 1) / LVL_PER_REG;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRA = 3'b001;
    localparam logic [2:0] MODE_ROR = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    // Everything an op needs to finish, carried stage to stage
    typedef struct packed {
        logic             valid;
        logic             err;
        logic             zero;
        logic [2:0]       mode;
        logic [SHW-1:0]   shamt;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q [LAT];
    stage_t stage_d [LAT];
    stage_t in_op_c;
    logic   adv_c;
    logic   in_ready_c;

    // One level: shift by 2^k in the op's mode; illegal modes pass data through
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [2:0]       mode,
                                                     input int unsigned      k);
        int unsigned sh;
        sh = 32'd1 << k;
        case (mode)
            MODE_SLL: shift_level = d << sh;
            MODE_SRA: shift_level = WIDTH'($signed(d) >>> sh);
            MODE_ROR: shift_level = (d >> sh) | (d << (WIDTH - sh));
            MODE_SRL: shift_level = d >> sh;
            MODE_ROL: shift_level = (d << sh) | (d >> (WIDTH - sh));
            default:  shift_level = d;
        endcase
    endfunction

    // Apply the levels owned by stage s to an op, chaining each level on the previous result
    function automatic stage_t advance_stage(input stage_t st, input int unsigned s);
        stage_t      r;
        int unsigned lvl;
        r = st;
        for (int unsigned j = 0; j < LVL_PER_REG; j++) begin
            lvl = s * LVL_PER_REG + j;
            if (lvl < SHW) begin
                if (r.shamt[lvl]) begin
                    r.data = shift_level(r.data, r.mode, lvl);
                end
            end
        end
        r.zero = (r.data == '0);
        return r;
    endfunction

    // Handshake: the pipe moves whenever the output slot is empty or being drained
    always_comb begin
        adv_c      = bus.out_ready | ~stage_q[LAT-1].valid;
        in_ready_c = adv_c & ~flush & rst_n;
    end

    // Capture the incoming op into stage form
    always_comb begin
        in_op_c       = '0;
        in_op_c.valid = bus.in_valid & in_ready_c;
        in_op_c.err   = (bus.in_mode > MODE_ROL);
        in_op_c.mode  = bus.in_mode;
        in_op_c.shamt = bus.in_shamt;
        in_op_c.tag   = bus.in_tag;
        in_op_c.data  = bus.in_data;
    end

    // Next state of every stage: advance all (bubbles included) or hold; flush kills valids
    always_comb begin
        stage_d = stage_q;
        if (adv_c) begin
            stage_d[0] = advance_stage(in_op_c, 0);
            for (int unsigned s = 1; s < LAT; s++) begin
                stage_d[s] = advance_stage(stage_q[s-1], s);
            end
        end
        if (flush) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                stage_d[s].valid = 1'b0;
            end
        end
    end

    // Stage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    // Busy whenever any stage holds a live op
    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s < LAT; s++) begin
            busy = busy | stage_q[s].valid;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = stage_q[LAT-1].valid;
    assign bus.out_data  = stage_q[LAT-1].data;
    assign bus.out_tag   = stage_q[LAT-1].tag;
    assign bus.out_zero  = stage_q[LAT-1].zero;
    assign bus.out_err   = stage_q[LAT-1].err;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=16, LVL_PER_REG=1, TAG_W=4, latency 4).
module tb_pipelined_shifter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned SHW   = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             err;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    pipelined_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_shifter #(.WIDTH(WIDTH), .LVL_PER_REG(1), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];

    // Reference: apply the shift one bit position at a time, shamt times
    function automatic res_t model(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                                   input logic [2:0] mode, input logic [TAG_W-1:0] tag);
        res_t             r;
        logic [WIDTH-1:0] v;
        v = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (mode)
                3'd0:    v = {v[WIDTH-2:0], 1'b0};
                3'd1:    v = {v[WIDTH-1], v[WIDTH-1:1]};
                3'd2:    v = {v[0], v[WIDTH-1:1]};
                3'd3:    v = {1'b0, v[WIDTH-1:1]};
                3'd4:    v = {v[WIDTH-2:0], v[WIDTH-1]};
                default: v = v;
            endcase
        end
        r.data = v;
        r.tag  = tag;
        r.zero = (v == '0);
        r.err  = (mode > 3'd4);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Record accepted ops (with model result) and delivered results
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_data, bus.in_shamt, bus.in_mode, bus.in_tag));
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_q.push_back('{data: bus.out_data, tag: bus.out_tag, zero: bus.out_zero, err: bus.out_err});
            got_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic set_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                          input logic [2:0] mode, input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
    endtask

    // Issue one op into an idle pipe; return edges until out_valid (-1 on timeout) and the result
    task automatic send_measure(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                                input logic [2:0] mode, input logic [TAG_W-1:0] tag,
                                output int lat, output res_t r);
        bus.out_ready = 1'b1;
        set_op(d, sh, mode, tag);
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        r = '{data: bus.out_data, tag: bus.out_tag, zero: bus.out_zero, err: bus.out_err};
    endtask

    // Drain with out_ready high; ok=0 if the pipe never empties
    task automatic drain(output bit ok);
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        step();
        ok = !busy;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
        checks++; if (bus.out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", bus.out_tag); end
        checks++; if (bus.out_zero !== 1'b0) begin failures++; $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero); end
        checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] dv [9];
        logic [3:0]  sv [9];
        logic [2:0]  mv [9];
        logic [15:0] ev [9];
        logic        zv [9];
        logic        errv [9];
        int          lat;
        res_t        r;
        dv   = '{16'h00FF, 16'h8000, 16'h8000, 16'h4000, 16'h1234, 16'h8001, 16'hABCD, 16'h1234, 16'h8000};
        sv   = '{4'd8, 4'd15, 4'd15, 4'd14, 4'd4, 4'd1, 4'd15, 4'd3, 4'd1};
        mv   = '{3'b000, 3'b011, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b111, 3'b000};
        ev   = '{16'hFF00, 16'h0001, 16'hFFFF, 16'h0001, 16'h4123, 16'h0003, 16'h579B, 16'h1234, 16'h0000};
        zv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        errv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            send_measure(dv[i], sv[i], mv[i], 4'(i), lat, r);
            checks++; if (lat != 4) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
            checks++; if (r.data !== ev[i]) begin failures++; $display("FAIL dir%0d_data got=%h exp=%h", i, r.data, ev[i]); end
            checks++; if (r.zero !== zv[i]) begin failures++; $display("FAIL dir%0d_zero got=%b exp=%b", i, r.zero, zv[i]); end
            checks++; if (r.err !== errv[i]) begin failures++; $display("FAIL dir%0d_err got=%b exp=%b", i, r.err, errv[i]); end
            checks++; if (r.tag !== 4'(i)) begin failures++; $display("FAIL dir%0d_tag got=%h exp=%h", i, r.tag, 4'(i)); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        idle_inputs();
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            set_op(16'($urandom), 4'($urandom), 3'($urandom_range(0, 4)), 4'(i));
            step();
        end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_drain got=busy exp=idle"); end
        checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin
            failures++; $display("FAIL b2b_count got=%0d/%0d exp=8", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_q[i].tag !== 4'(i)) begin failures++; $display("FAIL b2b_tag%0d got=%h exp=%h", i, got_q[i].tag, 4'(i)); end
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_res%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
                checks++; if (got_cyc[i] != got_cyc[0] + i) begin failures++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        idle_inputs();
        clear_queues();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 4'(i + 4));
            step();
        end
        set_op(16'hBEEF, 4'd5, 3'b000, 4'hF);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_full_out_valid got=%b exp=1", bus.out_valid); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d_in_ready got=%b exp=0", c, bus.in_ready); end
            checks++; if (bus.out_data !== exp_q[0].data) begin failures++; $display("FAIL stall%0d_data got=%h exp=%h", c, bus.out_data, exp_q[0].data); end
            checks++; if (bus.out_tag !== 4'd4) begin failures++; $display("FAIL stall%0d_tag got=%h exp=4", c, bus.out_tag); end
            step();
        end
        bus.in_valid = 1'b0;
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_drain got=busy exp=idle"); end
        checks++; if (got_q.size() != 4 || exp_q.size() != 4) begin
            failures++; $display("FAIL stall_count got=%0d/%0d exp=4", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_res%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        idle_inputs();
        clear_queues();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0)
                set_op(16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
            else
                bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_drain got=busy exp=idle"); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_res%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // Kill 3 in-flight ops by flush (use_reset=0) or by reset (use_reset=1)
    task automatic test_flush(input bit use_reset);
        int   lat;
        int   seen;
        res_t r;
        res_t e;
        idle_inputs();
        clear_queues();
        for (int i = 0; i < 3; i++) begin
            set_op(16'($urandom) | 16'h1, 4'($urandom), 3'($urandom_range(0, 4)), 4'(i));
            step();
        end
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL kill%0d_inflight got=busy%b/ov%b exp=busy1/ov0", use_reset, busy, bus.out_valid);
        end
        set_op(16'h5A5A, 4'd1, 3'b000, 4'h9);
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL kill%0d_in_ready got=%b exp=0", use_reset, bus.in_ready); end
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill%0d_busy got=%b exp=0", use_reset, busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL kill%0d_out_valid got=%b exp=0", use_reset, bus.out_valid); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen++;
            step();
        end
        checks++; if (seen != 0 || got_q.size() != 0) begin
            failures++; $display("FAIL kill%0d_ghost got=%0d/%0d exp=0", use_reset, seen, got_q.size());
        end
        e = model(16'hF00D, 4'd7, 3'b011, 4'hC);
        send_measure(16'hF00D, 4'd7, 3'b011, 4'hC, lat, r);
        checks++; if (lat != 4) begin failures++; $display("FAIL kill%0d_next_latency got=%0d exp=4", use_reset, lat); end
        checks++; if (r !== e) begin failures++; $display("FAIL kill%0d_next_res got=%h exp=%h", use_reset, r, e); end
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
